// File: rtl/clkstep_ctrl_pkg.sv
// Shared state encoding and default widths for the run/step clock controller.
// Reused by the front-panel display logic.
package clkstep_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t BURST = 2'd2;
    localparam state_t STEP  = 2'd3;

    localparam int CNT_W_DEF = 8;
    localparam int CYC_W_DEF = 16;

endpackage

// File: rtl/clkstep_ctrl_req_edge.sv
// Request qualifier: optional debounce (CLKSTEP_DEBOUNCE_EN), history register, rising-edge pulse.
// Pulse is combinational from the current sample; history resets high so a held request is not an edge.
module clkstep_ctrl_req_edge #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic pulse
);

    logic hist;
    logic lvl;

`ifdef CLKSTEP_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Counter starts saturated so a request held through reset qualifies at once and makes no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CMAX;
        end else if (!req) begin
            cnt <= '0;
        end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = req && (cnt == CMAX);
`else
    logic unused_deb;
    assign unused_deb = (DEB_CYCLES > 1);
    assign lvl = req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 1'b1;
        end else begin
            hist <= lvl;
        end
    end

    assign pulse = lvl && !hist;

endmodule

// File: rtl/clkstep_ctrl.sv
// Run/step controller producing a registered, edge-aligned enable for the clock gate cell.
// Optional request debounce via CLKSTEP_DEBOUNCE_EN; en/busy reflect the next state with no extra latency.
module clkstep_ctrl
    import clkstep_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DEB_CYCLES = 4,
    parameter int CYC_W      = CYC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             burst_req,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             halt,
    output logic             en,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [CYC_W-1:0] cyc_cnt
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_n;
    logic             run_edge;
    logic             step_edge;
    logic             burst_edge;

    clkstep_ctrl_req_edge #(.DEB_CYCLES(DEB_CYCLES)) u_run_edge (
        .clk   (clk),
        .rst   (rst),
        .req   (run_req),
        .pulse (run_edge)
    );

    clkstep_ctrl_req_edge #(.DEB_CYCLES(DEB_CYCLES)) u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .req   (step_req),
        .pulse (step_edge)
    );

    clkstep_ctrl_req_edge #(.DEB_CYCLES(DEB_CYCLES)) u_burst_edge (
        .clk   (clk),
        .rst   (rst),
        .req   (burst_req),
        .pulse (burst_edge)
    );

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        if (stop_req || halt) begin
            state_n     = IDLE;
            remaining_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero-length burst edge still wins priority over run; it just does nothing.
                    if (step_edge) begin
                        state_n = STEP;
                    end else if (burst_edge) begin
                        if (burst_len != '0) begin
                            state_n     = BURST;
                            remaining_n = burst_len;
                        end
                    end else if (run_edge) begin
                        state_n = RUN;
                    end
                end
                STEP: state_n = IDLE;
                BURST: begin
                    remaining_n = remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
            cyc_cnt   <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            en        <= (state_n != IDLE);
            busy      <= (state_n != IDLE);
            if (en) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_clkstep_ctrl.sv
// Directed bench for clkstep_ctrl; inputs change 1ns after the rising edge, outputs are checked there too.
module tb_clkstep_ctrl;

    logic        clk;
    logic        rst;
    logic        run_req;
    logic        stop_req;
    logic        step_req;
    logic        burst_req;
    logic [7:0]  burst_len;
    logic        halt;
    logic        en;
    logic        busy;
    logic [1:0]  state_o;
    logic [15:0] cyc_cnt;

    int n_checks;
    int n_fail;
    int n_en;

    clkstep_ctrl #(.CNT_W(8), .DEB_CYCLES(4), .CYC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_req   (run_req),
        .stop_req  (stop_req),
        .step_req  (step_req),
        .burst_req (burst_req),
        .burst_len (burst_len),
        .halt      (halt),
        .en        (en),
        .busy      (busy),
        .state_o   (state_o),
        .cyc_cnt   (cyc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then one idle edge with all requests low to clear the history registers.
    task automatic do_reset();
        run_req   = 1'b0;
        step_req  = 1'b0;
        burst_req = 1'b0;
        stop_req  = 1'b0;
        halt      = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic count_en(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            n += int'(en);
            tick();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        run_req   = 1'b1;
        stop_req  = 1'b0;
        step_req  = 1'b0;
        burst_req = 1'b0;
        burst_len = 8'd0;
        halt      = 1'b0;

        // Reset with run_req held high
        tick();
        tick();
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_o, 0);
        chk("rst_cyc", cyc_cnt, 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("held_run_no_edge", en, 0);

`ifdef CLKSTEP_DEBOUNCE_EN
        run_req = 1'b0;
        tick();
        step_req = 1'b1;
        count_en(3, n_en);
        chk("deb_short_en", n_en, 0);
        step_req = 1'b0;
        tick();
        chk("deb_short_state", state_o, 0);
        step_req = 1'b1;
        tick();
        tick();
        tick();
        chk("deb_pre_en", en, 0);
        tick();
        chk("deb_accept_en", en, 1);
        chk("deb_accept_state", state_o, 3);
        tick();
        chk("deb_step_done", en, 0);
        step_req = 1'b0;
        tick();
        chk("deb_cyc", cyc_cnt, 1);
`else
        run_req = 1'b0;
        tick();
        run_req = 1'b1;
        tick();
        chk("run_en", en, 1);
        chk("run_state", state_o, 1);
        tick();
        tick();
        tick();
        chk("run_cyc", cyc_cnt, 3);
        stop_req = 1'b1;
        tick();
        chk("stop_en", en, 0);
        chk("stop_state", state_o, 0);
        chk("stop_cyc", cyc_cnt, 4);
        stop_req = 1'b0;
        run_req  = 1'b0;

        // Single step with a 3-cycle request
        do_reset();
        step_req = 1'b1;
        tick();
        chk("step_en", en, 1);
        chk("step_busy", busy, 1);
        chk("step_state", state_o, 3);
        tick();
        chk("step_en_off", en, 0);
        chk("step_busy_off", busy, 0);
        chk("step_state_idle", state_o, 0);
        tick();
        chk("step_held_no_repeat", en, 0);
        chk("step_cyc", cyc_cnt, 1);
        step_req = 1'b0;

        // Burst of 5, then zero-length burst
        do_reset();
        burst_len = 8'd5;
        burst_req = 1'b1;
        tick();
        chk("burst5_first", en, 1);
        chk("burst5_state", state_o, 2);
        count_en(10, n_en);
        chk("burst5_count", n_en, 5);
        chk("burst5_idle", state_o, 0);
        chk("burst5_cyc", cyc_cnt, 5);
        burst_req = 1'b0;
        tick();
        burst_len = 8'd0;
        burst_req = 1'b1;
        count_en(6, n_en);
        chk("burst0_count", n_en, 0);
        chk("burst0_state", state_o, 0);
        burst_req = 1'b0;

        // Maximum burst length
        do_reset();
        burst_len = 8'd255;
        burst_req = 1'b1;
        tick();
        count_en(260, n_en);
        chk("burst255_count", n_en, 255);
        chk("burst255_cyc", cyc_cnt, 255);
        burst_req = 1'b0;

        // Halt terminates run, blocks a step edge
        do_reset();
        run_req = 1'b1;
        tick();
        chk("halt_run_en", en, 1);
        halt     = 1'b1;
        step_req = 1'b1;
        tick();
        chk("halt_en", en, 0);
        chk("halt_state", state_o, 0);
        halt = 1'b0;
        tick();
        chk("halt_step_lost", en, 0);
        step_req = 1'b0;
        run_req  = 1'b0;
        tick();
        step_req = 1'b1;
        count_en(4, n_en);
        chk("post_halt_step", n_en, 1);
        step_req = 1'b0;

        // Simultaneous run and step edges
        do_reset();
        run_req  = 1'b1;
        step_req = 1'b1;
        tick();
        chk("prio_state", state_o, 3);
        count_en(4, n_en);
        chk("prio_count", n_en, 1);
        chk("prio_run_dropped", state_o, 0);
        run_req  = 1'b0;
        step_req = 1'b0;

        // Stop during a 10-cycle burst after 4 enabled cycles
        do_reset();
        burst_len = 8'd10;
        burst_req = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("bstop_pre_en", en, 1);
        stop_req = 1'b1;
        tick();
        chk("bstop_en", en, 0);
        chk("bstop_cyc", cyc_cnt, 4);
        chk("bstop_remaining", dut.remaining, 0);
        chk("bstop_state", state_o, 0);
        stop_req  = 1'b0;
        burst_req = 1'b0;
        tick();
        chk("bstop_stays", en, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
